// File: rtl/debounce_ctrl.sv
// debounce_ctrl: qualifies a synchronized input bit over STABLE_CNT samples; optional lockout via DEB_HOLDOFF_EN
module debounce_ctrl #(
    parameter int STABLE_CNT  = 16,
    parameter int CNT_WIDTH   = 8,
    parameter int HOLDOFF_CNT = 32
) (
    input  logic CLK,
    input  logic RST,
    input  logic NOISY_SYNC,
    input  logic EN,
    output logic DEB_OUT,
    output logic RISE_PULSE,
    output logic FALL_PULSE,
    output logic BUSY
);
`ifdef DEB_HOLDOFF_EN
    typedef enum logic [2:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW, HOLDOFF} state_t;
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLDOFF_CNT - 1);
    localparam state_t AFTER_RISE = HOLDOFF;
    localparam state_t AFTER_FALL = HOLDOFF;
`else
    typedef enum logic [1:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW} state_t;
    localparam state_t AFTER_RISE = IDLE_HIGH;
    localparam state_t AFTER_FALL = IDLE_LOW;
`endif
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_CNT - 1);
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    // qualification FSM with registered level and edge pulses
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            DEB_OUT    <= 1'b0;
            RISE_PULSE <= 1'b0;
            FALL_PULSE <= 1'b0;
        end else begin
            RISE_PULSE <= 1'b0;
            FALL_PULSE <= 1'b0;
            case (state)
                IDLE_LOW: if (EN && NOISY_SYNC) begin
                    state <= CHECK_HIGH;
                    cnt   <= CNT_WIDTH'(1);
                end
                CHECK_HIGH: if (!EN || !NOISY_SYNC) begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state      <= AFTER_RISE;
                    DEB_OUT    <= 1'b1;
                    RISE_PULSE <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                IDLE_HIGH: if (EN && !NOISY_SYNC) begin
                    state <= CHECK_LOW;
                    cnt   <= CNT_WIDTH'(1);
                end
                CHECK_LOW: if (!EN || NOISY_SYNC) begin
                    state <= IDLE_HIGH;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state      <= AFTER_FALL;
                    DEB_OUT    <= 1'b0;
                    FALL_PULSE <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`ifdef DEB_HOLDOFF_EN
                HOLDOFF: if (cnt == HOLD_LAST) begin
                    state <= DEB_OUT ? IDLE_HIGH : IDLE_LOW;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end
    // busy whenever a qualification or lockout is in progress
    always_comb begin
`ifdef DEB_HOLDOFF_EN
        BUSY = (state == CHECK_HIGH) || (state == CHECK_LOW) || (state == HOLDOFF);
`else
        BUSY = (state == CHECK_HIGH) || (state == CHECK_LOW);
`endif
    end
endmodule

// File: tb/tb_debounce_ctrl.sv
// tb_debounce_ctrl: directed and randomized checks of debounce_ctrl against a run-length reference model
module tb_debounce_ctrl;
    localparam int SC = 4;
    localparam int HC = 5;
`ifdef DEB_HOLDOFF_EN
    localparam int HOLD = HC;
`else
    localparam int HOLD = 0;
`endif
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic NOISY_SYNC = 1'b0;
    logic EN = 1'b1;
    logic DEB_OUT, RISE_PULSE, FALL_PULSE, BUSY;
    int tests = 0;
    int fails = 0;
    int streak = 0;
    int hold = 0;
    bit lvl = 1'b0;
    bit m_rise = 1'b0;
    bit m_fall = 1'b0;

    debounce_ctrl #(.STABLE_CNT(SC), .CNT_WIDTH(8), .HOLDOFF_CNT(HC)) dut (
        .CLK(CLK), .RST(RST), .NOISY_SYNC(NOISY_SYNC), .EN(EN),
        .DEB_OUT(DEB_OUT), .RISE_PULSE(RISE_PULSE), .FALL_PULSE(FALL_PULSE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic got, logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        streak = 0;
        hold   = 0;
        lvl    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
    endfunction

    // one sampling edge: count consecutive enabled samples differing from the committed level
    function automatic void model(bit n, bit e);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (hold > 0) hold--;
        else if (e && n != lvl) begin
            streak++;
            if (streak == SC) begin
                lvl    = n;
                m_rise = n;
                m_fall = !n;
                streak = 0;
                hold   = HOLD;
            end
        end else streak = 0;
    endfunction

    task automatic check_all(string tag);
        chk({tag, "_deb"}, DEB_OUT, lvl);
        chk({tag, "_rise"}, RISE_PULSE, m_rise);
        chk({tag, "_fall"}, FALL_PULSE, m_fall);
        chk({tag, "_busy"}, BUSY, (streak > 0) || (hold > 0));
    endtask

    task automatic step(bit n, bit e, string tag);
        NOISY_SYNC = n;
        EN = e;
        @(posedge CLK);
        model(n, e);
        #1;
        check_all(tag);
    endtask

    task automatic settle(bit n);
        repeat (SC + HC + 2) step(n, 1'b1, "settle");
    endtask

    initial begin
        bit n;
        bit e;
        model_reset();
        #1;
        check_all("reset");
        #13 RST = 1'b1;
        @(negedge CLK);
        // rise after SC samples from reset release
        for (int i = 0; i < SC; i++) step(1'b1, 1'b1, "p1");
        chk("p1_deb_const", DEB_OUT, 1'b1);
        chk("p1_rise_const", RISE_PULSE, 1'b1);
        step(1'b1, 1'b1, "p1_after");
        chk("p1_rise_gone", RISE_PULSE, 1'b0);
        settle(1'b0);
        // glitch shorter than SC
        for (int i = 0; i < SC - 1; i++) step(1'b1, 1'b1, "p2");
        step(1'b0, 1'b1, "p2_drop");
        chk("p2_deb_const", DEB_OUT, 1'b0);
        chk("p2_busy_const", BUSY, 1'b0);
        // fall from committed high
        settle(1'b1);
        for (int i = 0; i < SC; i++) step(1'b0, 1'b1, "p3");
        settle(1'b0);
        // EN=0 aborts qualification
        step(1'b1, 1'b1, "p4a");
        step(1'b1, 1'b1, "p4b");
        step(1'b1, 1'b0, "p4_dis");
        step(1'b1, 1'b0, "p4_dis2");
        for (int i = 0; i < SC; i++) step(1'b1, 1'b1, "p4_req");
        settle(1'b0);
        // async reset mid-qualification
        step(1'b1, 1'b1, "p5a");
        step(1'b1, 1'b1, "p5b");
        #2 RST = 1'b0;
        #1;
        model_reset();
        check_all("p5_async");
        #1 RST = 1'b1;
        for (int i = 0; i < SC; i++) step(1'b1, 1'b1, "p5_req");
        settle(1'b1);
        // async reset with committed high level
        #2 RST = 1'b0;
        #1;
        model_reset();
        check_all("p5_high_rst");
        #1 RST = 1'b1;
`ifdef DEB_HOLDOFF_EN
        for (int i = 0; i < SC; i++) step(1'b1, 1'b1, "p6_rise");
        for (int i = 0; i < HC; i++) step(i[0], 1'b1, "p6_hold");
        for (int i = 0; i < SC; i++) step(1'b0, 1'b1, "p6_fall");
        settle(1'b0);
`endif
        // bursty random input with occasional disables
        n = 1'b0;
        repeat (600) begin
            if ($urandom_range(5) == 0) n = !n;
            e = ($urandom_range(15) != 0);
            step(n, e, "rnd");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/debounce_ctrl.md
Name: debounce_ctrl

Overview:
Debounce controller sequencing a qualification counter on one already-synchronized input bit.
- Sits directly after the multi-stage bit synchronizer in the debouncing path.
- The input changes the clean output only after holding a new level for STABLE_CNT consecutive clock samples.
- Emits a clean level, single-cycle rise/fall pulses, and a busy indication for a downstream event/interrupt block.

Parameters:
STABLE_CNT, 16, consecutive identical samples required to commit a new level; legal range 2..2^CNT_WIDTH-1
CNT_WIDTH, 8, width of the qualification counter
HOLDOFF_CNT, 32, post-commit lockout length in cycles; used only when DEB_HOLDOFF_EN is defined; legal range 1..2^CNT_WIDTH-1

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
NOISY_SYNC  input  1  synchronized but undebounced input level
EN  input  1  debounce enable; 0 freezes the committed level and aborts qualification
DEB_OUT  output  1  debounced level, registered
RISE_PULSE  output  1  one-cycle pulse on a committed 0->1 transition, registered
FALL_PULSE  output  1  one-cycle pulse on a committed 1->0 transition, registered
BUSY  output  1  high while in CHECK_HIGH, CHECK_LOW or HOLDOFF; decoded from the state register

Behaviour:
- Reset (RST=0, async):
  - state=IDLE_LOW, cnt=0.
  - DEB_OUT=0, RISE_PULSE=0, FALL_PULSE=0, BUSY=0.
  - Takes effect immediately, including mid-qualification; any partial count is discarded.
- States: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW (plus HOLDOFF if enabled).
- IDLE_LOW:
  - EN=1 and NOISY_SYNC=1 -> CHECK_HIGH, cnt<=1.
  - Otherwise stay.
- CHECK_HIGH:
  - NOISY_SYNC=0 -> IDLE_LOW, cnt<=0. Glitch: no output change, no pulse.
  - NOISY_SYNC=1 and cnt==STABLE_CNT-1 -> IDLE_HIGH, DEB_OUT<=1, RISE_PULSE<=1, cnt<=0.
  - NOISY_SYNC=1 otherwise -> cnt<=cnt+1.
- IDLE_HIGH and CHECK_LOW mirror the above with the polarity inverted; a commit drives DEB_OUT<=0 and FALL_PULSE<=1.
- Latency: DEB_OUT changes on the same edge that takes the STABLE_CNT-th consecutive new-level sample; the first of those samples is the one taken in the IDLE state.
- RISE_PULSE and FALL_PULSE:
  - Default 0 each cycle; high for exactly one cycle after a commit.
  - Never high simultaneously.
- EN=0 has priority over NOISY_SYNC:
  - CHECK_HIGH -> IDLE_LOW and CHECK_LOW -> IDLE_HIGH, cnt<=0.
  - IDLE states hold; DEB_OUT holds; no pulses.
- Counter:
  - Only compared against STABLE_CNT-1 and never exceeds it, so it cannot wrap.
  - STABLE_CNT outside the legal range is a configuration error.
- An input that returns to the committed level on the commit cycle itself is already sampled too late; the commit happens.

Optional Feature:
Macro DEB_HOLDOFF_EN.
- Defined:
  - Every commit enters HOLDOFF instead of the IDLE state, with cnt<=0.
  - NOISY_SYNC is ignored during HOLDOFF; cnt increments each cycle.
  - At cnt==HOLDOFF_CNT-1 the FSM goes to IDLE_HIGH or IDLE_LOW, matching DEB_OUT, with cnt<=0.
  - BUSY=1 throughout HOLDOFF.
  - EN=0 does not shorten HOLDOFF.
- Not defined: no HOLDOFF state, no holdoff logic; HOLDOFF_CNT is unused.

Test Plan:
1. STABLE_CNT=4, NOISY_SYNC=1 held from reset release -> DEB_OUT rises on the 4th sampling edge; RISE_PULSE=1 for exactly that one cycle; BUSY=1 for the 3 cycles before.
2. NOISY_SYNC high for 3 cycles, then low -> DEB_OUT stays 0, no pulses, FSM back in IDLE_LOW with BUSY=0.
3. DEB_OUT=1, NOISY_SYNC low for 4 cycles -> DEB_OUT falls, FALL_PULSE one cycle; RISE_PULSE stays 0 throughout.
4. EN=0 asserted after 2 high samples -> BUSY drops next cycle. After EN returns to 1 with input still high, a full 4 new samples are needed before DEB_OUT=1.
5. RST pulsed low during CHECK_HIGH at cnt=2 -> all outputs 0 immediately, asynchronously. After release, re-qualification needs 4 samples.
6. DEB_HOLDOFF_EN defined, HOLDOFF_CNT=5 -> after a rise commit, toggle NOISY_SYNC every cycle for 5 cycles: DEB_OUT stays 1 and BUSY=1. Then hold low 4 cycles -> FALL_PULSE.
